br_pht: RTL and testbench

//   Pattern history table: an array of 2-bit saturating branch counters.
//   - Sits between fetch (lookup, upstream) and branch resolution/commit (update, downstream).
//   - Produces the taken/not-taken prediction one cycle after a fetch lookup.
//   - Trains the indexed counter when a resolved branch reports its outcome.

---
 rtl/br_pht_pkg.sv | 18 +
 rtl/br_pht_sat_ctr_next.sv | 22 ++
 rtl/br_pht.sv | 106 ++++++++++
 tb/tb_br_pht.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/br_pht_pkg.sv
// Shared types for the branch pattern history table: the 2-bit saturating
// counter encoding and its reset value.
package br_pht_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } pht_ctr_t;

    localparam pht_ctr_t PHT_RESET_CTR = WEAK_T;

    function automatic logic ctr_predicts_taken(input pht_ctr_t ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/br_pht_sat_ctr_next.sv
// Next-state function of one 2-bit saturating branch counter.
// Clamps at STRONG_NT and STRONG_T, so the counter never wraps around.
module br_sat_ctr_next
    import br_pht_pkg::*;
(
    input  pht_ctr_t ctr,
    input  logic     taken,
    output pht_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            STRONG_NT: ctr_next = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_next = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_next = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_next = taken ? STRONG_T : WEAK_T;
            default:   ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/br_pht.sv
// Pattern history table of 2-bit counters with a one-cycle registered lookup.
// Define BR_PHT_GSHARE_EN to XOR a speculative global history into the index.
module br_pht
    import br_pht_pkg::*;
#(
    parameter int PHT_IDX_W = 6,
    parameter int GHR_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 resp_valid,
    output logic                 resp_taken,
    output logic [PHT_IDX_W-1:0] resp_idx,
    output logic [GHR_W-1:0]     resp_ghr,
    input  logic                 upd_valid,
    input  logic [PHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken,
    input  logic                 upd_mispred,
    input  logic [GHR_W-1:0]     upd_ghr
);

    localparam int PHT_ENTRIES = 1 << PHT_IDX_W;

    pht_ctr_t             ctr_q [PHT_ENTRIES];
    pht_ctr_t             upd_cur;
    pht_ctr_t             upd_next;
    pht_ctr_t             look_ctr;
    logic                 look_taken;
    logic [PHT_IDX_W-1:0] pc_idx;
    logic [PHT_IDX_W-1:0] look_idx;

    wire unused_pc_bits = ^{lookup_pc[31:PHT_IDX_W+2], lookup_pc[1:0]};

    assign pc_idx  = lookup_pc[PHT_IDX_W+1:2];
    assign upd_cur = ctr_q[upd_idx];

    br_sat_ctr_next u_sat_ctr_next (
        .ctr      (upd_cur),
        .taken    (upd_taken),
        .ctr_next (upd_next)
    );

    // A lookup hitting the index being trained this cycle sees the trained value.
    always_comb begin
        look_ctr = ctr_q[look_idx];
        if (upd_valid && (upd_idx == look_idx)) begin
            look_ctr = upd_next;
        end
        look_taken = ctr_predicts_taken(look_ctr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                ctr_q[i] <= PHT_RESET_CTR;
            end
        end else if (upd_valid) begin
            ctr_q[upd_idx] <= upd_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_idx   <= '0;
        end else begin
            resp_valid <= lookup_valid;
            if (lookup_valid) begin
                resp_taken <= look_taken;
                resp_idx   <= look_idx;
            end
        end
    end

`ifdef BR_PHT_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    assign look_idx = pc_idx ^ ghr_q;

    // Misprediction repair rebuilds history from the branch's snapshot and beats any speculative shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q    <= '0;
            resp_ghr <= '0;
        end else begin
            if (upd_valid && upd_mispred) begin
                ghr_q <= {upd_ghr[GHR_W-2:0], upd_taken};
            end else if (lookup_valid) begin
                ghr_q <= {ghr_q[GHR_W-2:0], look_taken};
            end
            if (lookup_valid) begin
                resp_ghr <= ghr_q;
            end
        end
    end
`else
    wire unused_ghr_inputs = ^{upd_ghr, upd_mispred};

    assign look_idx = pc_idx;
    assign resp_ghr = '0;
`endif

endmodule

// File: tb/tb_br_pht.sv
// Directed bench for br_pht: reset state, training, saturation, bypass and
// asynchronous reset; the BR_PHT_GSHARE_EN build runs the history sequence instead.
module tb_br_pht;

    localparam int PHT_IDX_W = 6;
    localparam int GHR_W     = 6;

    logic                 clk;
    logic                 rst;
    logic                 lookup_valid;
    logic [31:0]          lookup_pc;
    logic                 resp_valid;
    logic                 resp_taken;
    logic [PHT_IDX_W-1:0] resp_idx;
    logic [GHR_W-1:0]     resp_ghr;
    logic                 upd_valid;
    logic [PHT_IDX_W-1:0] upd_idx;
    logic                 upd_taken;
    logic                 upd_mispred;
    logic [GHR_W-1:0]     upd_ghr;

    int total = 0;
    int bad   = 0;

    br_pht #(.PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .resp_valid   (resp_valid),
        .resp_taken   (resp_taken),
        .resp_idx     (resp_idx),
        .resp_ghr     (resp_ghr),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .upd_mispred  (upd_mispred),
        .upd_ghr      (upd_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic lv, input logic [31:0] pc,
                                 input logic uv, input logic [5:0] uidx, input logic ut,
                                 input logic um, input logic [5:0] ughr);
        lookup_valid = lv;
        lookup_pc    = pc;
        upd_valid    = uv;
        upd_idx      = uidx;
        upd_taken    = ut;
        upd_mispred  = um;
        upd_ghr      = ughr;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        lookup_valid = 0; lookup_pc = 0; upd_valid = 0; upd_idx = 0;
        upd_taken = 0; upd_mispred = 0; upd_ghr = 0;
        #3 doReset();
        checkOutput("rst_valid", 32'(resp_valid), 0);
        checkOutput("rst_taken", 32'(resp_taken), 0);
        checkOutput("rst_idx",   32'(resp_idx),   0);
        checkOutput("rst_ghr",   32'(resp_ghr),   0);

`ifndef BR_PHT_GSHARE_EN
        $display("[TB] lookup after reset");
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("t1_valid", 32'(resp_valid), 1);
        checkOutput("t1_taken", 32'(resp_taken), 1);
        checkOutput("t1_idx",   32'(resp_idx),   32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_idle_valid", 32'(resp_valid), 0);

        $display("[TB] training idx 0x10 down and back up");
        applyStimulus(0, 0, 1, 6'h10, 0, 0, 0);
        applyStimulus(0, 0, 1, 6'h10, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("t2_nt_taken", 32'(resp_taken), 0);
        applyStimulus(0, 0, 1, 6'h10, 0, 0, 0);
        applyStimulus(0, 0, 1, 6'h10, 0, 0, 0);
        applyStimulus(0, 0, 1, 6'h10, 1, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("t2_wnt_taken", 32'(resp_taken), 0);
        checkOutput("t2_wnt_idx",   32'(resp_idx),   32'h10);
        applyStimulus(0, 0, 1, 6'h10, 1, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("t2_wt_taken", 32'(resp_taken), 1);

        $display("[TB] saturation at strong taken on idx 5");
        applyStimulus(0, 0, 1, 6'd5, 1, 0, 0);
        applyStimulus(0, 0, 1, 6'd5, 1, 0, 0);
        applyStimulus(0, 0, 1, 6'd5, 1, 0, 0);
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
        checkOutput("t3_st_taken", 32'(resp_taken), 1);
        checkOutput("t3_st_idx",   32'(resp_idx),   5);
        applyStimulus(0, 0, 1, 6'd5, 0, 0, 0);
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
        checkOutput("t3_wt_taken", 32'(resp_taken), 1);

        $display("[TB] same-cycle bypass");
        applyStimulus(1, 32'h14, 1, 6'd5, 0, 0, 0);
        checkOutput("t4_bypass_taken", 32'(resp_taken), 0);
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
        checkOutput("t4_after_taken", 32'(resp_taken), 0);
        applyStimulus(1, 32'h40, 1, 6'd5, 0, 0, 0);
        checkOutput("t4_other_taken", 32'(resp_taken), 1);
        checkOutput("t4_other_idx",   32'(resp_idx),   32'h10);
        applyStimulus(1, 32'h18, 0, 0, 0, 0, 0);
        checkOutput("t4_idx6_taken", 32'(resp_taken), 1);
        applyStimulus(1, 32'h14, 1, 6'd5, 1, 0, 0);
        checkOutput("t4_sat_low_taken", 32'(resp_taken), 0);

        $display("[TB] asynchronous reset mid-response");
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
        checkOutput("t5_pre_valid", 32'(resp_valid), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_async_valid", 32'(resp_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, 32'(i) << 2, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t5_taken_%0d", i), 32'(resp_taken), 1);
            checkOutput($sformatf("t5_idx_%0d", i),   32'(resp_idx),   32'(i));
        end
`else
        $display("[TB] global history sequence");
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("g_l1_ghr",   32'(resp_ghr),   0);
        checkOutput("g_l1_idx",   32'(resp_idx),   32'h10);
        checkOutput("g_l1_taken", 32'(resp_taken), 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("g_l2_ghr", 32'(resp_ghr), 1);
        checkOutput("g_l2_idx", 32'(resp_idx), 32'h11);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("g_l3_ghr", 32'(resp_ghr), 3);
        checkOutput("g_l3_idx", 32'(resp_idx), 32'h13);
        applyStimulus(1, 32'h40, 1, 6'h20, 0, 1, 6'b000001);
        checkOutput("g_l4_ghr", 32'(resp_ghr), 7);
        checkOutput("g_l4_idx", 32'(resp_idx), 32'h17);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("g_repair_ghr", 32'(resp_ghr), 2);
        checkOutput("g_repair_idx", 32'(resp_idx), 2);
`endif

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("end_idle_valid", 32'(resp_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
